// File: rtl/updown_counter.sv
// updown_counter: loadable up/down counter, wrap or saturate at 0/MAX, Carry/Borrow event pulses; Q/Carry/Borrow valid one cycle after the sampling edge, no backpressure.
// Defining COUNTER_PRESCALER_EN adds a prescaler so only every PRESCALE-th enabled cycle is a step.
module updown_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX         = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESCALE    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             Set_Enable,
  input  logic             Count_Enable,
  input  logic             Up,
  input  logic             Saturate,
  output logic [WIDTH-1:0] Q,
  output logic             Carry,
  output logic             Borrow,
  output logic             Zero
);

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic             r_borrow;

  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_carry_nxt;
  logic             w_borrow_nxt;
  logic             w_step;

`ifdef COUNTER_PRESCALER_EN
  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  // Only the last enabled cycle of each prescale window is a step.
  assign w_step = Count_Enable && !Set_Enable && (r_pre == PRE_LAST);

  always_ff @(posedge clock) begin
    if (reset || Set_Enable) begin
      r_pre <= '0;
    end else if (Count_Enable) begin
      r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
    end
  end
`else
  assign w_step = Count_Enable && !Set_Enable;
`endif

  assign w_load_val = (Data > MAX) ? MAX : Data;

  always_comb begin
    w_q_nxt      = r_q;
    w_carry_nxt  = 1'b0;
    w_borrow_nxt = 1'b0;
    if (Set_Enable) begin
      w_q_nxt = w_load_val;
    end else if (w_step) begin
      if (Up) begin
        if (r_q == MAX) begin
          w_carry_nxt = 1'b1;
          w_q_nxt     = Saturate ? MAX : '0;
        end else begin
          w_q_nxt = r_q + WIDTH'(1);
        end
      end else begin
        if (r_q == '0) begin
          w_borrow_nxt = 1'b1;
          w_q_nxt      = Saturate ? '0 : MAX;
        end else begin
          w_q_nxt = r_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q      <= RESET_VALUE;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_q      <= w_q_nxt;
      r_carry  <= w_carry_nxt;
      r_borrow <= w_borrow_nxt;
    end
  end

  assign Q      = r_q;
  assign Carry  = r_carry;
  assign Borrow = r_borrow;
  assign Zero   = (r_q == '0);

endmodule
